// File: rtl/pe_pkg.sv
// ============================================================================
// pe_pkg : precision-mode encodings and helpers shared by the PE adder path
// Revision: 1.0
// ============================================================================
`default_nettype none

package pe_pkg;

    localparam int PRECISION_CONFIG_L = 2;

    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'b00;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'b01;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'b10;

    // Any code that is not a known narrow mode runs as a full-width add.
    function automatic logic [PRECISION_CONFIG_L-1:0] normalize_mode(
        input logic [PRECISION_CONFIG_L-1:0] mode
    );
        if ((mode == PRECISION_CONFIG_8B) || (mode == PRECISION_CONFIG_16B)) begin
            return mode;
        end
        return PRECISION_CONFIG_32B;
    endfunction

    function automatic logic [2:0] lane_capacity(
        input logic [PRECISION_CONFIG_L-1:0] mode
    );
        case (mode)
            PRECISION_CONFIG_8B:  return 3'd4;
            PRECISION_CONFIG_16B: return 3'd2;
            default:              return 3'd1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_decomposable.sv
// ============================================================================
// adder_decomposable : N_ADDERS lane adders whose carries chain per precision
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_decomposable
    import pe_pkg::*;
#(
    parameter int EACH_ADDER_LEN = 8,
    parameter int N_ADDERS       = 4
) (
    input  logic [PRECISION_CONFIG_L-1:0]              mode,
    input  logic [N_ADDERS*EACH_ADDER_LEN-1:0]         in0,
    input  logic [N_ADDERS*EACH_ADDER_LEN-1:0]         in1,
    output logic [N_ADDERS-1:0][EACH_ADDER_LEN:0]      out_quart,
    output logic [N_ADDERS/2-1:0][2*EACH_ADDER_LEN:0]  out_half,
    output logic [N_ADDERS*EACH_ADDER_LEN:0]           out_full
);

    logic [N_ADDERS-1:0][EACH_ADDER_LEN-1:0] w_lsum;
    logic [N_ADDERS-1:0]                     w_cout;
    logic                                    w_carry;

    // True when the carry out of lane k-1 feeds lane k in this mode.
    function automatic logic lane_linked(
        input logic [PRECISION_CONFIG_L-1:0] m,
        input int                            k
    );
        if (k == 0) begin
            return 1'b0;
        end
        if (m == PRECISION_CONFIG_8B) begin
            return 1'b0;
        end
        if (m == PRECISION_CONFIG_16B) begin
            return (k % 2) == 1;
        end
        return 1'b1;
    endfunction

    always_comb begin
        w_carry = 1'b0;
        w_lsum  = '0;
        w_cout  = '0;
        for (int k = 0; k < N_ADDERS; k++) begin
            if (!lane_linked(mode, k)) begin
                w_carry = 1'b0;
            end
            {w_cout[k], w_lsum[k]} = {1'b0, in0[k*EACH_ADDER_LEN +: EACH_ADDER_LEN]}
                                   + {1'b0, in1[k*EACH_ADDER_LEN +: EACH_ADDER_LEN]}
                                   + {{EACH_ADDER_LEN{1'b0}}, w_carry};
            w_carry = w_cout[k];
        end
    end

    for (genvar k = 0; k < N_ADDERS; k++) begin : g_quart
        assign out_quart[k] = {w_cout[k], w_lsum[k]};
    end

    for (genvar j = 0; j < N_ADDERS/2; j++) begin : g_half
        assign out_half[j] = {w_cout[2*j+1], w_lsum[2*j+1], w_lsum[2*j]};
    end

    assign out_full = {w_cout[N_ADDERS-1], w_lsum};

endmodule

`default_nettype wire

// File: rtl/adder_lane_scheduler.sv
// ============================================================================
// adder_lane_scheduler : packs same-precision requests onto one shared
// decomposable adder, returning per-requester sums two cycles after grant
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_lane_scheduler
    import pe_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int EACH_ADDER_LEN = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [N_REQ-1:0]                             req_valid,
    input  logic [N_REQ-1:0][PRECISION_CONFIG_L-1:0]     req_mode,
    input  logic [N_REQ-1:0][4*EACH_ADDER_LEN-1:0]       req_in0,
    input  logic [N_REQ-1:0][4*EACH_ADDER_LEN-1:0]       req_in1,
    output logic [N_REQ-1:0]                             req_ready,
    output logic [N_REQ-1:0]                             resp_valid,
    output logic [N_REQ-1:0][4*EACH_ADDER_LEN:0]         resp_sum
);

    localparam int C_N_LANES = 4;
    localparam int C_WORD_W  = C_N_LANES * EACH_ADDER_LEN;
    localparam int C_SUM_W   = C_WORD_W + 1;
    localparam int C_HALF_W  = 2 * EACH_ADDER_LEN;
    localparam int C_PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [C_PTR_W-1:0]                          r_rr_ptr;
    logic                                        r_s1_valid;
    logic [C_WORD_W-1:0]                         r_s1_in0;
    logic [C_WORD_W-1:0]                         r_s1_in1;
    logic [PRECISION_CONFIG_L-1:0]               r_s1_mode;
    logic [C_N_LANES-1:0][C_PTR_W-1:0]           r_s1_owner;
    logic [C_N_LANES-1:0]                        r_s1_used;
    logic [N_REQ-1:0]                            r_resp_valid;
    logic [N_REQ-1:0][C_SUM_W-1:0]               r_resp_sum;

    logic [N_REQ-1:0][C_PTR_W-1:0]               w_rr_idx;
    logic [N_REQ-1:0]                            w_grant;
    logic                                        w_found;
    logic [PRECISION_CONFIG_L-1:0]               w_mode;
    logic [2:0]                                  w_cap;
    logic [2:0]                                  w_count;
    logic [C_PTR_W-1:0]                          w_last;
    logic [C_N_LANES-1:0][C_PTR_W-1:0]           w_owner;
    logic [C_N_LANES-1:0]                        w_used;
    logic [C_WORD_W-1:0]                         w_pack0;
    logic [C_WORD_W-1:0]                         w_pack1;

    logic [C_N_LANES-1:0][EACH_ADDER_LEN:0]      w_out_quart;
    logic [C_N_LANES/2-1:0][C_HALF_W:0]          w_out_half;
    logic [C_WORD_W:0]                           w_out_full;
    logic [C_N_LANES-1:0][C_SUM_W-1:0]           w_lane_result;

    function automatic logic [C_PTR_W-1:0] rr_index(
        input logic [C_PTR_W-1:0] base,
        input int                 offset
    );
        int s;
        s = int'(base) + offset;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return C_PTR_W'(s);
    endfunction

    always_comb begin
        w_rr_idx = '0;
        for (int o = 0; o < N_REQ; o++) begin
            w_rr_idx[o] = rr_index(r_rr_ptr, o);
        end
    end

    // Walk requesters in round-robin order: the first valid one fixes the
    // cycle's precision, later ones join only if they match and a lane is free.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_mode  = PRECISION_CONFIG_32B;
        w_cap   = 3'd1;
        w_count = 3'd0;
        w_last  = '0;
        w_owner = '0;
        for (int o = 0; o < N_REQ; o++) begin
            if (req_valid[w_rr_idx[o]]) begin
                if (!w_found) begin
                    w_found              = 1'b1;
                    w_mode               = normalize_mode(req_mode[w_rr_idx[o]]);
                    w_cap                = lane_capacity(w_mode);
                    w_grant[w_rr_idx[o]] = 1'b1;
                    w_owner[0]           = w_rr_idx[o];
                    w_count              = 3'd1;
                    w_last               = w_rr_idx[o];
                end else if ((w_count < w_cap) &&
                             (normalize_mode(req_mode[w_rr_idx[o]]) == w_mode)) begin
                    w_grant[w_rr_idx[o]]  = 1'b1;
                    w_owner[w_count[1:0]] = w_rr_idx[o];
                    w_count               = w_count + 3'd1;
                    w_last                = w_rr_idx[o];
                end
            end
        end
        if (rst) begin
            w_grant = '0;
        end
    end

    assign req_ready = w_grant;

    always_comb begin
        w_used  = '0;
        w_pack0 = '0;
        w_pack1 = '0;
        for (int k = 0; k < C_N_LANES; k++) begin
            w_used[k] = (3'(k) < w_count);
        end
        case (w_mode)
            PRECISION_CONFIG_8B: begin
                for (int k = 0; k < C_N_LANES; k++) begin
                    if (w_used[k]) begin
                        w_pack0[k*EACH_ADDER_LEN +: EACH_ADDER_LEN] =
                            req_in0[w_owner[k]][EACH_ADDER_LEN-1:0];
                        w_pack1[k*EACH_ADDER_LEN +: EACH_ADDER_LEN] =
                            req_in1[w_owner[k]][EACH_ADDER_LEN-1:0];
                    end
                end
            end
            PRECISION_CONFIG_16B: begin
                for (int k = 0; k < C_N_LANES/2; k++) begin
                    if (w_used[k]) begin
                        w_pack0[k*C_HALF_W +: C_HALF_W] = req_in0[w_owner[k]][C_HALF_W-1:0];
                        w_pack1[k*C_HALF_W +: C_HALF_W] = req_in1[w_owner[k]][C_HALF_W-1:0];
                    end
                end
            end
            default: begin
                if (w_used[0]) begin
                    w_pack0 = req_in0[w_owner[0]];
                    w_pack1 = req_in1[w_owner[0]];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_in0   <= '0;
            r_s1_in1   <= '0;
            r_s1_mode  <= PRECISION_CONFIG_8B;
            r_s1_owner <= '0;
            r_s1_used  <= '0;
        end else begin
            r_s1_valid <= |w_grant;
            if (|w_grant) begin
                r_rr_ptr   <= rr_index(w_last, 1);
                r_s1_in0   <= w_pack0;
                r_s1_in1   <= w_pack1;
                r_s1_mode  <= w_mode;
                r_s1_owner <= w_owner;
                r_s1_used  <= w_used;
            end
        end
    end

    adder_decomposable #(
        .EACH_ADDER_LEN (EACH_ADDER_LEN),
        .N_ADDERS       (C_N_LANES)
    ) u_adder (
        .mode      (r_s1_mode),
        .in0       (r_s1_in0),
        .in1       (r_s1_in1),
        .out_quart (w_out_quart),
        .out_half  (w_out_half),
        .out_full  (w_out_full)
    );

    always_comb begin
        w_lane_result = '0;
        case (r_s1_mode)
            PRECISION_CONFIG_8B: begin
                for (int k = 0; k < C_N_LANES; k++) begin
                    w_lane_result[k] = C_SUM_W'(w_out_quart[k]);
                end
            end
            PRECISION_CONFIG_16B: begin
                for (int k = 0; k < C_N_LANES/2; k++) begin
                    w_lane_result[k] = C_SUM_W'(w_out_half[k]);
                end
            end
            default: begin
                w_lane_result[0] = w_out_full;
            end
        endcase
    end

    // Non-owners keep their last sum; only the valid pulse is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= '0;
            r_resp_sum   <= '0;
        end else begin
            r_resp_valid <= '0;
            if (r_s1_valid) begin
                for (int k = 0; k < C_N_LANES; k++) begin
                    if (r_s1_used[k]) begin
                        r_resp_valid[r_s1_owner[k]] <= 1'b1;
                        r_resp_sum[r_s1_owner[k]]   <= w_lane_result[k];
                    end
                end
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_sum   = r_resp_sum;

endmodule

`default_nettype wire
